// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state encoding and address-check constant for data_mem_resp
//   state_t  : S_IDLE=0, S_WAIT=1, S_RESP=2
//   ADDR_LSB : number of byte-offset bits below the word index
package mem_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;
    localparam int ADDR_LSB = 2;
endpackage

// File: rtl/ram_sp.sv
// ram_sp: single-port 32-bit RAM, synchronous write, asynchronous read, no reset
//   i_clk   : write clock
//   i_we    : write enable
//   i_addr  : word address (read and write)
//   i_wdata : write data
//   o_rdata : combinational read data at i_addr
module ram_sp #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: word memory behind a valid/ready request port with WAIT wait states
//   clk, reset (async, active-low)
//   req_valid/req_write/req_addr/req_wdata -> req_ready : request channel, one outstanding
//   resp_valid/resp_rdata/resp_err <- resp_ready        : response channel
module data_mem_resp
    import mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam bit DIRECT = (WAIT == 0);

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_write, r_err;
    logic [AW-1:0] r_addr;
    logic [31:0] r_wdata, r_rdata;

    logic          w_accept, w_req_err, w_go_resp, w_write, w_err, w_we;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_wdata, w_ram_rdata;

    // gating with reset keeps req_ready low while reset is held
    assign req_ready = reset & (r_state == S_IDLE);
    assign w_accept  = req_valid & req_ready;
    assign w_req_err = (req_addr[ADDR_LSB-1:0] != '0) | ((req_addr >> ADDR_LSB) >= 32'(DEPTH));

    // with no wait states the memory access happens on the accept edge itself,
    // so it must use the live request rather than the captured copy
    assign w_write = DIRECT ? req_write : r_write;
    assign w_err   = DIRECT ? w_req_err : r_err;
    assign w_addr  = DIRECT ? req_addr[ADDR_LSB +: AW] : r_addr;
    assign w_wdata = DIRECT ? req_wdata : r_wdata;

    assign w_go_resp = ((r_state == S_IDLE) & w_accept & DIRECT) |
                       ((r_state == S_WAIT) & (r_cnt == '0));
    assign w_we = w_go_resp & w_write & ~w_err;

    ram_sp #(.DEPTH(DEPTH)) u_ram (
        .i_clk  (clk),
        .i_we   (w_we),
        .i_addr (w_addr),
        .i_wdata(w_wdata),
        .o_rdata(w_ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = DIRECT ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_err   <= w_req_err;
                r_addr  <= req_addr[ADDR_LSB +: AW];
                r_wdata <= req_wdata;
                r_cnt   <= 4'(DIRECT ? 0 : WAIT - 1);
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_go_resp) r_rdata <= (w_write | w_err) ? 32'd0 : w_ram_rdata;
        end
    end

    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = resp_valid ? r_rdata : 32'd0;
    assign resp_err   = resp_valid & r_err;
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: randomized scoreboard bench for data_mem_resp (WAIT=2 main DUT, WAIT=0 side DUT)
module tb_data_mem_resp;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 0, reset = 0;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_write = 0, req_ready, resp_valid, resp_ready = 0, resp_err;
    logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata;
    logic        z_req_valid = 0, z_req_write = 0, z_req_ready, z_resp_valid, z_resp_err;
    logic        z_resp_ready = 1;
    logic [31:0] z_req_addr = 0, z_req_wdata = 0, z_resp_rdata;

    int          cyc = 0, errors = 0, checks = 0;
    bit          hold_low = 0, in_resp = 0;
    logic [31:0] mem_m [64];
    exp_t        q [$];

    data_mem_resp #(.DEPTH(64), .WAIT(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    data_mem_resp #(.DEPTH(64), .WAIT(0)) dut_z (
        .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_ready(z_req_ready),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
        .resp_err(z_resp_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // responder-side backpressure: random unless the bench forces it low
    initial forever begin
        @(posedge clk);
        #1;
        resp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // monitor: compares every cycle of a presented response against the queue head
    initial forever begin
        @(negedge clk);
        if (resp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                if (!in_resp) chk("latency", 32'(cyc - q[0].acc), 32'd3);
                chk("rdata", resp_rdata, q[0].rdata);
                chk("err", {31'd0, resp_err}, {31'd0, q[0].err});
                chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
                in_resp = 1;
                if (resp_ready) begin
                    void'(q.pop_front());
                    in_resp = 0;
                end
            end
        end else begin
            in_resp = 0;
            chk("idle_rdata", resp_rdata, 32'd0);
            chk("idle_err", {31'd0, resp_err}, 32'd0);
        end
    end

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int   t;
        bit   e_err;
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", {31'd0, req_ready}, 32'd1);
        if (req_ready) begin
            e_err   = (a[1:0] != 0) || ((a >> 2) >= 64);
            e.err   = e_err;
            e.rdata = (e_err || wr) ? 32'd0 : mem_m[int'(a[7:2])];
            e.acc   = cyc;
            if (!e_err && wr) mem_m[int'(a[7:2])] = d;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || resp_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int t;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 64; i++) issue(1, 32'(i * 4), $urandom);
        issue(1, 32'h64, 32'h7);
        issue(0, 32'h64, 32'h0);
        issue(1, 32'h60, 32'hA5A5_0001);
        issue(1, 32'h62, 32'h1234_5678);
        issue(0, 32'h60, 32'h0);
        issue(0, 32'h100, 32'h0);
        issue(1, 32'h100, 32'hFFFF_FFFF);
        issue(0, 32'hFC, 32'h0);
        drain();

        @(negedge clk);
        hold_low = 1;
        issue(0, 32'h64, 32'h0);
        t = 0;
        while (!resp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_rdata", resp_rdata, 32'h7);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        hold_low = 0;
        drain();

        @(posedge clk);
        #1;
        z_req_valid = 1; z_req_write = 1; z_req_addr = 32'h8; z_req_wdata = 32'h5A;
        @(negedge clk);
        chk("z_accept_st", {31'd0, z_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        z_req_valid = 0;
        @(negedge clk);
        chk("z_valid_st", {31'd0, z_resp_valid}, 32'd1);
        chk("z_err_st", {31'd0, z_resp_err}, 32'd0);
        @(posedge clk);
        #1;
        z_req_valid = 1; z_req_write = 0; z_req_addr = 32'h8;
        @(negedge clk);
        chk("z_accept_ld", {31'd0, z_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        z_req_valid = 0;
        @(negedge clk);
        chk("z_valid_ld", {31'd0, z_resp_valid}, 32'd1);
        chk("z_rdata_ld", z_resp_rdata, 32'h5A);
        @(negedge clk);
        chk("z_idle_after", {31'd0, z_resp_valid}, 32'd0);

        issue(1, 32'h10, 32'h1111_2222);
        drain();
        @(posedge clk);
        #1;
        req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rw_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 0;
        @(negedge clk);
        #2;
        reset = 0;
        #1;
        chk("rw_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rw_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rw_rdata", resp_rdata, 32'd0);
        chk("rw_err", {31'd0, resp_err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        chk("rw_ready_after", {31'd0, req_ready}, 32'd1);
        issue(0, 32'h10, 32'h0);
        drain();

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 511)) : 32'($urandom_range(0, 79) * 4);
            issue(1'($urandom_range(0, 1)), a, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
